// File: rtl/ade_packet_counter_if.sv
// Bundle of strobes into and results out of the ADE packet counter (fifo_clk domain).
// Master drives the timing strobes; slave is the counter itself.
interface ade_packet_counter_if #(
  parameter int PKT_LEN = 32,
  parameter int CNT_W   = 4
);
  localparam int WC_W = $clog2(PKT_LEN);

  logic             video_en;
  logic             ade;
  logic             adesig;
  logic             vde;
  logic [CNT_W-1:0] ade_num;
  logic             ade_num_vld;
  logic             ade_sat;
  logic             armed;
  logic [WC_W-1:0]  wcnt;

  modport master (
    output video_en, ade, adesig, vde,
    input  ade_num, ade_num_vld, ade_sat, armed, wcnt
  );

  modport slave (
    input  video_en, ade, adesig, vde,
    output ade_num, ade_num_vld, ade_sat, armed, wcnt
  );
endinterface

// File: rtl/ade_packet_counter.sv
// Counts PKT_LEN-word aux packets per blanking window and latches the count at window close.
// Optional feature macro ADE_PARTIAL_EN: count a packet on its first word (partial packets included).
module ade_packet_counter #(
  parameter int PKT_LEN      = 32,
  parameter int CNT_W        = 4,
  parameter bit CLR_ON_CLOSE = 1'b0
) (
  input logic                fifo_clk,
  input logic                sys_rst,
  ade_packet_counter_if.slave bus
);
  localparam int              WC_W    = $clog2(PKT_LEN);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(PKT_LEN - 1);

  typedef enum logic {DISARMED = 1'b0, ARMED = 1'b1} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_adesig_d;
  logic             r_vde_d;
  logic [WC_W-1:0]  r_wc;
  logic [CNT_W-1:0] r_pc;
  logic             r_sat_i;
  logic [CNT_W-1:0] r_ade_num;
  logic             r_ade_num_vld;
  logic             r_ade_sat;

  logic             w_armed;
  logic             w_word;
  logic             w_close;
  logic             w_inc;
  logic             w_pc_max;
  logic             w_inc_sat;
  logic [CNT_W-1:0] w_pc_next;

  assign w_armed   = (r_state == ARMED);
  assign w_word    = w_armed & bus.ade;
  assign w_close   = w_armed & ((bus.adesig & ~r_adesig_d) | (bus.vde & ~r_vde_d));

`ifdef ADE_PARTIAL_EN
  assign w_inc     = w_word & (r_wc == {WC_W{1'b0}});
`else
  assign w_inc     = w_word & (r_wc == WC_LAST);
`endif

  // The running count including this cycle's increment, so a close never drops it.
  assign w_pc_max  = &r_pc;
  assign w_inc_sat = w_inc & w_pc_max;
  assign w_pc_next = (w_inc && !w_pc_max) ? (r_pc + CNT_W'(1)) : r_pc;

  // Arming state register.
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      r_state <= DISARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arm on the first video_en sample; only reset disarms.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DISARMED: begin
        if (bus.video_en) begin
          w_state_nxt = ARMED;
        end else begin
          w_state_nxt = DISARMED;
        end
      end
      ARMED:   w_state_nxt = ARMED;
      default: w_state_nxt = DISARMED;
    endcase
  end

  // Delayed copies for rising-edge detection of the window-close strobes.
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      r_adesig_d <= 1'b0;
      r_vde_d    <= 1'b0;
    end else begin
      r_adesig_d <= bus.adesig;
      r_vde_d    <= bus.vde;
    end
  end

  // Word index within the current packet; an optional close-clear beats a coincident word.
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      r_wc <= {WC_W{1'b0}};
    end else if (w_close && CLR_ON_CLOSE) begin
      r_wc <= {WC_W{1'b0}};
    end else if (w_word) begin
      r_wc <= (r_wc == WC_LAST) ? {WC_W{1'b0}} : (r_wc + WC_W'(1));
    end else begin
      r_wc <= r_wc;
    end
  end

  // Packet count, sticky saturation and the latched per-window result.
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      r_pc          <= {CNT_W{1'b0}};
      r_sat_i       <= 1'b0;
      r_ade_num     <= {CNT_W{1'b0}};
      r_ade_num_vld <= 1'b0;
      r_ade_sat     <= 1'b0;
    end else if (w_close) begin
      r_ade_num     <= w_pc_next;
      r_ade_sat     <= r_sat_i | w_inc_sat;
      r_ade_num_vld <= 1'b1;
      r_pc          <= {CNT_W{1'b0}};
      r_sat_i       <= 1'b0;
    end else begin
      r_ade_num_vld <= 1'b0;
      r_pc          <= w_pc_next;
      r_sat_i       <= r_sat_i | w_inc_sat;
    end
  end

  assign bus.ade_num     = r_ade_num;
  assign bus.ade_num_vld = r_ade_num_vld;
  assign bus.ade_sat     = r_ade_sat;
  assign bus.armed       = w_armed;
  assign bus.wcnt        = r_wc;
endmodule

// File: tb/tb_ade_packet_counter.sv
// Directed bench: two counter instances (default, and PKT_LEN=4/CNT_W=2/CLR_ON_CLOSE=1)
// share stimulus; expected close results are queued per instance and checked on each strobe.
module tb_ade_packet_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ade_packet_counter_if #(.PKT_LEN(32), .CNT_W(4)) ifa ();
  ade_packet_counter_if #(.PKT_LEN(4),  .CNT_W(2)) ifb ();

  assign ifb.video_en = ifa.video_en;
  assign ifb.ade      = ifa.ade;
  assign ifb.adesig   = ifa.adesig;
  assign ifb.vde      = ifa.vde;

  ade_packet_counter #(.PKT_LEN(32), .CNT_W(4), .CLR_ON_CLOSE(1'b0)) dut_a (
    .fifo_clk(clk), .sys_rst(rst), .bus(ifa));
  ade_packet_counter #(.PKT_LEN(4), .CNT_W(2), .CLR_ON_CLOSE(1'b1)) dut_b (
    .fifo_clk(clk), .sys_rst(rst), .bus(ifb));

`ifdef ADE_PARTIAL_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int qa_num[$];
  int qa_sat[$];
  int qb_num[$];
  int qb_sat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic a, input logic s, input logic d);
    ifa.video_en = v;
    ifa.ade      = a;
    ifa.adesig   = s;
    ifa.vde      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic words(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Drive one close edge; the strobe must be visible right after the sampling edge.
  task automatic close(input bit use_vde, input bit with_word, input int ea, input int eas,
                       input int eb, input int ebs, input bit idle_after);
    qa_num.push_back(ea); qa_sat.push_back(eas);
    qb_num.push_back(eb); qb_sat.push_back(ebs);
    step(1'b0, with_word, !use_vde, use_vde);
    chk("vld_latency_a", {31'd0, ifa.ade_num_vld}, 32'd1);
    chk("vld_latency_b", {31'd0, ifb.ade_num_vld}, 32'd1);
    if (idle_after) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard for instance A: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ifa.ade_num_vld === 1'b1) begin
      if (qa_num.size() == 0) begin
        chk("unexpected_vld_a", 32'd1, 32'd0);
      end else begin
        chk("ade_num_a", {28'd0, ifa.ade_num}, qa_num.pop_front());
        chk("ade_sat_a", {31'd0, ifa.ade_sat}, qa_sat.pop_front());
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (ifb.ade_num_vld === 1'b1) begin
      if (qb_num.size() == 0) begin
        chk("unexpected_vld_b", 32'd1, 32'd0);
      end else begin
        chk("ade_num_b", {30'd0, ifb.ade_num}, qb_num.pop_front());
        chk("ade_sat_b", {31'd0, ifb.ade_sat}, qb_sat.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.video_en = 1'b0; ifa.ade = 1'b0; ifa.adesig = 1'b0; ifa.vde = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_num_a",   {28'd0, ifa.ade_num}, 32'd0);
    chk("rst_vld_a",   {31'd0, ifa.ade_num_vld}, 32'd0);
    chk("rst_sat_a",   {31'd0, ifa.ade_sat}, 32'd0);
    chk("rst_armed_a", {31'd0, ifa.armed}, 32'd0);
    chk("rst_wcnt_a",  {27'd0, ifa.wcnt}, 32'd0);

    // Disarmed: words and both edges must be ignored.
    words(5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_armed", {31'd0, ifa.armed}, 32'd0);
    chk("dis_wcnt",  {27'd0, ifa.wcnt}, 32'd0);
    chk("dis_num",   {28'd0, ifa.ade_num}, 32'd0);

    // Arm; a word in the arming sample cycle is dropped.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("arm_armed", {31'd0, ifa.armed}, 32'd1);
    chk("arm_wcnt",  {27'd0, ifa.wcnt}, 32'd0);

    // Three full packets; B saturates.
    words(96);
    close(1'b0, 1'b0, 3, 0, 3, 1, 1'b1);
    chk("w96_wcnt_a", {27'd0, ifa.wcnt}, 32'd0);

    // 40 words closed by vde.
    words(40);
    close(1'b1, 1'b0, P ? 2 : 1, 0, 3, 1, 1'b1);
    chk("w40_wcnt_a", {27'd0, ifa.wcnt}, 32'd8);
    chk("w40_wcnt_b", {30'd0, ifb.wcnt}, 32'd0);

    // Increment coincident with close, then a back-to-back vde close latching 0.
    words(P ? 56 : 55);
    close(1'b0, 1'b1, 2, 0, 3, 1, 1'b0);
    close(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
    chk("b2b_wcnt_a", {27'd0, ifa.wcnt}, P ? 32'd1 : 32'd0);

    // One B packet after saturation clears the sticky flag.
    words(4);
    close(1'b0, 1'b0, 0, 0, 1, 0, 1'b1);
    words(2);
    close(1'b1, 1'b0, 0, 0, P ? 1 : 0, 0, 1'b1);
    chk("part_wcnt_a", {27'd0, ifa.wcnt}, P ? 32'd7 : 32'd6);
    chk("clr_wcnt_b",  {30'd0, ifb.wcnt}, 32'd0);

    // Reset mid-window, re-arm, one full packet.
    words(20);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("mid_rst_armed", {31'd0, ifa.armed}, 32'd0);
    chk("mid_rst_wcnt",  {27'd0, ifa.wcnt}, 32'd0);
    chk("mid_rst_num_b", {30'd0, ifb.ade_num}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    words(32);
    close(1'b0, 1'b0, 1, 0, 3, 1, 1'b1);
    words(3);
    chk("hold_num_a", {28'd0, ifa.ade_num}, 32'd1);
    chk("hold_vld_a", {31'd0, ifa.ade_num_vld}, 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_a_drained", qa_num.size(), 32'd0);
    chk("queue_b_drained", qb_num.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ade_packet_counter.md
# ade_packet_counter

Parametrised audio-data-enable (ADE) packet counter in the `fifo_clk` domain, between the HDMI/TMDS receive timing and the `gmii_tx` sender. It counts PKT_LEN-word auxiliary packets written to the audio send FIFO during each blanking window. At every window close (rising `adesig` or rising `vde`) it latches the count as `ade_num` for the packet header. Compared with the earlier inline counter, it adds configurable packet length and count width, a same-cycle close/increment merge with no lost counts, saturation reporting and a validity strobe.

## Interface
- PKT_LEN, 32, words per aux packet; power of two, 2..256
- CNT_W, 4, width of packet count
- CLR_ON_CLOSE, 0, 1 = word counter also cleared on window close

- fifo_clk  in  1  pixel/FIFO write clock; only clock
- sys_rst  in  1  reset; synchronous, active-high
- video_en  in  1  video active; arms the block
- ade  in  1  aux word strobe (one word per cycle)
- adesig  in  1  aux transmit request; rising edge closes window
- vde  in  1  video data enable; rising edge closes window
- ade_num  out  CNT_W  packet count of last closed window
- ade_num_vld  out  1  one-cycle pulse when ade_num updates
- ade_sat  out  1  last closed window saturated
- armed  out  1  block armed
- wcnt  out  log2(PKT_LEN)  current word index within packet

## Operation
- States: DISARMED, ARMED. DISARMED -> ARMED on first cycle with `video_en`=1. Stays ARMED until `sys_rst`. No counting, closing or strobing while DISARMED.
- Edge detect: registered copies `adesig_d` and `vde_d`, reset 0. `close` = armed & ((adesig & ~adesig_d) | (vde & ~vde_d)). Both edges in one cycle = one close.
- `word` = armed & ade.
- Word counter `wc`: on `word`, wc = (wc==PKT_LEN-1) ? 0 : wc+1. Natural binary wrap. `wcnt` = wc.
- Packet increment `inc`: see Configuration (start-of-packet or end-of-packet).
- Packet counter `pc` (CNT_W bits): on `inc`, pc+1, saturating at 2^CNT_W-1. Increment attempted at max sets sticky `sat_i`.
- On `close`:
  - ade_num <= pc + inc (saturating).
  - ade_sat <= sat_i, or this cycle's increment saturates.
  - ade_num_vld <= 1.
  - pc <= 0, sat_i <= 0.
  - If CLR_ON_CLOSE=1, wc <= 0; this takes priority over `word`.
  - A same-cycle increment is never lost.
- ade_num and ade_sat hold between closes.

## Timing
- Reset values: ade_num=0, ade_num_vld=0, ade_sat=0, armed=0, wcnt=0; internal pc, sat_i, adesig_d, vde_d are 0.
- Reset mid-window: all state returns to reset values at the next edge. The block must re-arm via `video_en`.
- `armed` rises on the edge after the first `video_en`=1 sample. A `word` or `close` in that same sample cycle is ignored.
- Close latency: edge present at sample t -> ade_num/ade_num_vld valid after edge t+1. ade_num_vld is high exactly one cycle.
- Back-to-back closes (edges on consecutive cycles are impossible per signal, but an adesig edge and a vde edge can fall in adjacent cycles): each one produces its own strobe. The second strobe latches 0 plus any increment in its cycle.
- Throughput: one word per cycle, no stall.

## Configuration
- ADE_PARTIAL_EN defined: inc = word & (wc==0). A packet counts on its first word, so packets cut short by a close are included.
- ADE_PARTIAL_EN undefined: inc = word & (wc==PKT_LEN-1). Only complete packets count. A partial packet's remaining words carry into the next window unless CLR_ON_CLOSE=1.

## Test plan
- Defaults, ADE_PARTIAL_EN defined: video_en pulse, 96 ade words, then adesig rise -> ade_num=3, ade_num_vld single pulse one cycle after edge, ade_sat=0.
- Defaults, macro undefined: 40 words, then vde rise -> ade_num=1, wcnt=8. With CLR_ON_CLOSE=1, wcnt=0 after close.
- Same-cycle: 32nd-complete / 33rd-word increment coincident with adesig rise (macro defined, word 33) -> ade_num=2, next window starts at 0.
- Saturation: CNT_W=2, 5 packets of PKT_LEN=4 -> ade_num=3, ade_sat=1. Next window with 1 packet -> ade_num=1, ade_sat=0.
- Disarmed: ade words and adesig/vde edges before any video_en -> armed=0, no ade_num_vld, outputs stay 0.
- Reset mid-window: 20 words, sys_rst for 1 cycle, video_en, 32 words, adesig rise -> ade_num=1.
